// File: rtl/rca8_accum.sv
// ============================================================================
// Module      : rca8_accum (with helper rca8)
// Description : Frame accumulator built around one 8-bit ripple-carry adder.
//               Each accepted operand is folded into a 16-bit total in two
//               passes through the adder: low byte first, then high byte
//               plus the carry from the low pass. When the frame's last
//               operand has been added, the total, a sticky overflow flag
//               and the saturating operand count are presented until the
//               consumer takes them.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports (rca8_accum):
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand valid
//   in_data    in   8      operand, unsigned
//   in_last    in   1      final operand of the frame (qualified by in_valid)
//   in_ready   out  1      stage can accept an operand
//   out_valid  out  1      frame result valid
//   out_ready  in   1      consumer accepts the result
//   out_sum    out  16     accumulated frame total
//   out_ovf    out  1      sticky: total overflowed 16 bits during the frame
//   out_count  out  CNT_W  operands in the frame, saturating at all-ones
// Parameters:
//   CNT_W      width of the operand counter (default 8)
// Build option:
//   RCA_ACC_SAT_EN  when defined, the total clamps at 16'hFFFF on overflow
//                   instead of wrapping modulo 2^16.
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// rca8 : plain 8-bit ripple-carry adder, one full adder per bit.
// ----------------------------------------------------------------------------
module rca8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] s_o,
   output logic       cout_o
);

   logic [8:0] w_carry;

   assign w_carry[0] = cin_i;

   generate
      for (genvar i = 0; i < 8; i++) begin : g_bit
         assign s_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
         assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
      end
   endgenerate

   assign cout_o = w_carry[8];

endmodule

// ----------------------------------------------------------------------------
// rca8_accum : top level
// ----------------------------------------------------------------------------
module rca8_accum #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADD_LO = 2'd1,
      S_ADD_HI = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      acc_q,   acc_d;
   logic [7:0]       op_q,    op_d;
   logic             last_q,  last_d;
   logic             c_q,     c_d;
   logic             ovf_q,   ovf_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [7:0]       w_add_a;
   logic [7:0]       w_add_b;
   logic             w_add_cin;
   logic [7:0]       w_add_s;
   logic             w_add_cout;

   // -------------------------------------------------------------------------
   // Adder operand mux. Kept in its own process so that it depends only on
   // registered state; the next-state process consumes the adder result.
   // -------------------------------------------------------------------------
   always_comb begin
      w_add_a   = 8'h00;
      w_add_b   = 8'h00;
      w_add_cin = 1'b0;
      case (state_q)
         S_ADD_LO: begin
            w_add_a   = acc_q[7:0];
            w_add_b   = op_q;
            w_add_cin = 1'b0;
         end
         S_ADD_HI: begin
            // High byte only absorbs the carry from the low pass.
            w_add_a   = acc_q[15:8];
            w_add_b   = 8'h00;
            w_add_cin = c_q;
         end
         default: begin
            w_add_a   = 8'h00;
            w_add_b   = 8'h00;
            w_add_cin = 1'b0;
         end
      endcase
   end

   rca8 u_rca8 (
      .a_i    (w_add_a),
      .b_i    (w_add_b),
      .cin_i  (w_add_cin),
      .s_o    (w_add_s),
      .cout_o (w_add_cout)
   );

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      last_d  = last_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone qualifies.
            if (in_valid) begin
               op_d    = in_data;
               last_d  = in_last;
               state_d = S_ADD_LO;
            end
         end

         S_ADD_LO: begin
            acc_d[7:0] = w_add_s;
            c_d        = w_add_cout;
`ifdef RCA_ACC_SAT_EN
            // Once clamped, the total stays at 16'hFFFF for the frame.
            if (ovf_q) begin
               acc_d[7:0] = acc_q[7:0];
            end
`endif
            state_d = S_ADD_HI;
         end

         S_ADD_HI: begin
            acc_d[15:8] = w_add_s;
            ovf_d       = ovf_q | w_add_cout;
`ifdef RCA_ACC_SAT_EN
            if (ovf_q | w_add_cout) begin
               acc_d = 16'hFFFF;
            end
`endif
            // Counter holds at all-ones rather than wrapping.
            if (&cnt_q) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = last_q ? S_DONE : S_IDLE;
         end

         S_DONE: begin
            // Result registers are untouched here, so they stay stable while
            // the consumer stalls.
            if (out_ready) begin
               acc_d   = 16'h0000;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= 16'h0000;
         op_q    <= 8'h00;
         last_q  <= 1'b0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         last_q  <= last_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: straight from registers or decoded from the state register.
   // -------------------------------------------------------------------------
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = cnt_q;

endmodule

`default_nettype wire
